// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXE/MEM/WB and decodes datapath controls.
// Optional macro MCTRL_PERF_EN adds free-running cycle_cnt and retired-instruction instr_cnt outputs.
module multi_cycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        im_ready,
    input  logic        dm_ready,
    output logic        pc_wr,
    output logic [1:0]  npc_op,
    output logic        ir_wr,
    output logic        rf_wr,
    output logic        dm_wr,
    output logic        dm_rd,
    output logic [1:0]  wd_sel,
    output logic [1:0]  reg_dst,
    output logic        alu_src,
    output logic        ext_op,
    output logic [2:0]  alu_op,
    output logic        illegal,
    output logic [2:0]  state
`ifdef MCTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_RS  = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXE    = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
    logic legal;

    logic       pc_wr_c, ir_wr_c, rf_wr_c, dm_wr_c, dm_rd_c, illegal_c;
    logic [1:0] npc_op_c, wd_sel_c, reg_dst_c;
    logic       alu_src_c, ext_op_c;
    logic [2:0] alu_op_c;

    always_comb begin
        is_addu = (opcode == OP_RTYPE) && (funct == FN_ADDU);
        is_subu = (opcode == OP_RTYPE) && (funct == FN_SUBU);
        is_jr   = (opcode == OP_RTYPE) && (funct == FN_JR);
        is_ori  = (opcode == OP_ORI);
        is_lui  = (opcode == OP_LUI);
        is_lw   = (opcode == OP_LW);
        is_sw   = (opcode == OP_SW);
        is_beq  = (opcode == OP_BEQ);
        is_j    = (opcode == OP_J);
        is_jal  = (opcode == OP_JAL);
        legal   = is_addu | is_subu | is_jr | is_ori | is_lui |
                  is_lw | is_sw | is_beq | is_j | is_jal;
    end

    always_comb begin
        state_d   = state_q;
        pc_wr_c   = 1'b0;
        npc_op_c  = NPC_PC4;
        ir_wr_c   = 1'b0;
        rf_wr_c   = 1'b0;
        dm_wr_c   = 1'b0;
        dm_rd_c   = 1'b0;
        wd_sel_c  = 2'b00;
        reg_dst_c = 2'b00;
        alu_src_c = 1'b0;
        ext_op_c  = 1'b0;
        alu_op_c  = ALU_ADD;
        illegal_c = 1'b0;

        // ALU controls are held steady from EXE through WB so the result stays valid.
        if (state_q == EXE || state_q == MEM || state_q == WB) begin
            if (is_subu) begin
                alu_op_c = ALU_SUB;
            end else if (is_ori) begin
                alu_src_c = 1'b1;
                alu_op_c  = ALU_OR;
            end else if (is_lui) begin
                alu_src_c = 1'b1;
                alu_op_c  = ALU_LUI;
            end else if (is_lw || is_sw) begin
                alu_src_c = 1'b1;
                ext_op_c  = 1'b1;
            end else if (is_beq) begin
                ext_op_c  = 1'b1;
                alu_op_c  = ALU_SUB;
            end
        end

        case (state_q)
            FETCH: begin
                if (im_ready) begin
                    ir_wr_c = 1'b1;
                    pc_wr_c = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (is_j) begin
                    pc_wr_c  = 1'b1;
                    npc_op_c = NPC_J;
                    state_d  = FETCH;
                end else if (is_jal) begin
                    pc_wr_c   = 1'b1;
                    npc_op_c  = NPC_J;
                    rf_wr_c   = 1'b1;
                    reg_dst_c = 2'b10;
                    wd_sel_c  = 2'b10;
                    state_d   = FETCH;
                end else if (is_jr) begin
                    pc_wr_c  = 1'b1;
                    npc_op_c = NPC_RS;
                    state_d  = FETCH;
                end else if (!legal) begin
                    illegal_c = 1'b1;
                    state_d   = FETCH;
                end else begin
                    state_d = EXE;
                end
            end
            EXE: begin
                if (is_beq) begin
                    pc_wr_c  = zero;
                    npc_op_c = NPC_BR;
                    state_d  = FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = MEM;
                end else if (is_addu || is_subu || is_ori || is_lui) begin
                    state_d = WB;
                end else begin
                    state_d = FETCH;
                end
            end
            MEM: begin
                if (is_sw) begin
                    dm_wr_c = 1'b1;
                    if (dm_ready) state_d = FETCH;
                end else if (is_lw) begin
                    dm_rd_c = 1'b1;
                    if (dm_ready) state_d = WB;
                end else begin
                    state_d = FETCH;
                end
            end
            WB: begin
                rf_wr_c = 1'b1;
                state_d = FETCH;
                if (is_addu || is_subu) begin
                    reg_dst_c = 2'b01;
                end else if (is_lw) begin
                    wd_sel_c = 2'b01;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are gated by rst_n so nothing fires while reset is held, even with im_ready high.
    always_comb begin
        pc_wr   = rst_n & pc_wr_c;
        ir_wr   = rst_n & ir_wr_c;
        rf_wr   = rst_n & rf_wr_c;
        dm_wr   = rst_n & dm_wr_c;
        dm_rd   = rst_n & dm_rd_c;
        illegal = rst_n & illegal_c;
        npc_op  = rst_n ? npc_op_c  : 2'b00;
        wd_sel  = rst_n ? wd_sel_c  : 2'b00;
        reg_dst = rst_n ? reg_dst_c : 2'b00;
        alu_src = rst_n & alu_src_c;
        ext_op  = rst_n & ext_op_c;
        alu_op  = rst_n ? alu_op_c  : 3'b000;
        state   = state_q;
    end

`ifdef MCTRL_PERF_EN
    logic [31:0] cycle_cnt_q, instr_cnt_q;
    logic        retire;

    // A legal instruction retires on any transition back to FETCH from an active state.
    always_comb begin
        retire = legal && !illegal_c && (state_d == FETCH) &&
                 (state_q == DECODE || state_q == EXE || state_q == MEM || state_q == WB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= 32'd0;
            instr_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (retire) instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Multi-cycle MIPS control FSM; sequences the shared datapath (PC, IR, register file, ALU, DM) over FETCH/DECODE/EXE/MEM/WB.
- Drives datapath mux selects: write-data 3:1 (ALU/DM/PC+4), write-register 3:1 (rt/rd/$31), ALU-B 2:1.
- Waits on ready handshakes from the instruction and data memories.

Parameters:
- None.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU equal flag.
- im_ready  in  1  instruction memory data valid this cycle.
- dm_ready  in  1  data memory access complete this cycle.
- pc_wr  out  1  PC write enable.
- npc_op  out  2  next-PC source: 00 PC+4, 01 branch target, 10 jump target, 11 GPR[rs].
- ir_wr  out  1  IR write enable.
- rf_wr  out  1  register file write enable.
- dm_wr  out  1  data memory write request.
- dm_rd  out  1  data memory read request.
- wd_sel  out  2  write-data select: 00 ALU, 01 DM, 10 PC+4.
- reg_dst  out  2  write-register select: 00 rt, 01 rd, 10 $31.
- alu_src  out  1  ALU B: 0 GPR[rt], 1 extended immediate.
- ext_op  out  1  1 sign-extend, 0 zero-extend.
- alu_op  out  3  000 add, 001 sub, 010 or, 011 lui (imm<<16).
- illegal  out  1  one-cycle pulse on an unsupported instruction.
- state  out  3  current state, for debug.

Behaviour:
- Supported instructions: addu (000000/100001), subu (000000/100011), jr (000000/001000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- State encoding: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. Codes 5–7 go to FETCH on the next edge with all enables 0.
- State is the only register. All outputs decode combinationally from state, opcode, funct and zero. Every enable is forced to 0 while rst_n=0.
- Reset: state=FETCH asynchronously. All enables, illegal, npc_op, wd_sel, reg_dst, alu_src, ext_op and alu_op read 0. A reset mid-instruction abandons it; no partial writes follow.
- FETCH:
  - im_ready=0: hold, all enables 0.
  - im_ready=1: ir_wr=1, pc_wr=1, npc_op=00, then go to DECODE.
  - From here on the PC holds PC+4.
- DECODE:
  - j: pc_wr=1, npc_op=10, then FETCH.
  - jal: pc_wr=1, npc_op=10, rf_wr=1, reg_dst=10, wd_sel=10, then FETCH.
  - jr: pc_wr=1, npc_op=11, then FETCH.
  - Unsupported: illegal=1 for this cycle, no writes, then FETCH.
  - All others: go to EXE.
- EXE:
  - alu_src, ext_op and alu_op are set per instruction.
  - beq: alu_op=001, alu_src=0. pc_wr=zero, npc_op=01, then FETCH.
  - lw/sw: alu_op=000, alu_src=1, ext_op=1, then MEM.
  - addu/subu/ori/lui: go to WB.
- MEM:
  - alu_src=1 and ext_op=1 are held.
  - sw: dm_wr=1 until the dm_ready cycle, then FETCH.
  - lw: dm_rd=1 until the dm_ready cycle, then WB.
  - dm_ready=0: stay in MEM, holding the request.
- WB: rf_wr=1 for one cycle, then FETCH.
  - addu/subu: reg_dst=01, wd_sel=00, alu_src=0, alu_op 000 or 001.
  - ori: reg_dst=00, wd_sel=00, alu_src=1, ext_op=0, alu_op=010.
  - lui: reg_dst=00, wd_sel=00, alu_src=1, alu_op=011.
  - lw: reg_dst=00, wd_sel=01.
- Latency with ready tied high:
  - j/jal/jr: 2 cycles.
  - beq: 3 cycles.
  - sw and R/ori/lui: 4 cycles.
  - lw: 5 cycles.
- rf_wr, pc_wr and dm_wr are never high outside the cycles listed above.

Optional Feature:
- Macro MCTRL_PERF_EN adds two outputs:
  - cycle_cnt[31:0]: increments every clock.
  - instr_cnt[31:0]: increments on each return to FETCH from a legal instruction.
  - Both clear on reset and wrap at 2^32−1 to 0.
- Without the macro, neither port exists and no counter logic is present.

Test Plan:
- rst_n=0 mid-MEM of sw with dm_ready=0 -> state=0 immediately, dm_wr=0. After release, FETCH resumes with no write.
- addu, ready high -> states 0,1,2,4. WB cycle shows rf_wr=1, reg_dst=01, wd_sel=00, alu_op=000. 4 cycles total.
- lw with dm_ready low 3 cycles in MEM -> dm_rd=1 held 4 cycles, then WB with wd_sel=01, reg_dst=00. No rf_wr before WB.
- beq, zero=1 then zero=0 -> pc_wr=1 with npc_op=01 in EXE for the first, pc_wr=0 for the second. Both return to FETCH.
- jal -> DECODE shows pc_wr=1, npc_op=10, rf_wr=1, reg_dst=10, wd_sel=10. Next state is 0.
- opcode 111111 -> illegal pulses one cycle in DECODE, no enables asserted. With MCTRL_PERF_EN, instr_cnt is unchanged.
